// File: rtl/branch_pkg.sv
// Shared constants for the branch resolve unit: B-type funct3 encodings and default widths.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int XLEN_DEFAULT        = 32;
    localparam int INSTR_BYTES_DEFAULT = 4;
    localparam int CNT_W_DEFAULT       = 32;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/response bundle of the branch resolve unit; signal suffixes are from the resolver's point of view.
interface branch_resolve_unit_if
    import branch_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
);

    logic             flush_i;
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       funct3_i;
    logic [XLEN-1:0]  rs1_i;
    logic [XLEN-1:0]  rs2_i;
    logic [XLEN-1:0]  pc_i;
    logic [XLEN-1:0]  imm_i;
    logic             pred_taken_i;
    logic [XLEN-1:0]  pred_target_i;
    logic             valid_o;
    logic             ready_i;
    logic             taken_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic             mispredict_o;
    logic             illegal_o;
    logic             misaligned_o;
    logic [CNT_W-1:0] branch_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    modport slave (
        input  flush_i, valid_i, funct3_i, rs1_i, rs2_i, pc_i, imm_i,
               pred_taken_i, pred_target_i, ready_i,
        output ready_o, valid_o, taken_o, redirect_pc_o, mispredict_o,
               illegal_o, misaligned_o, branch_cnt_o, mispred_cnt_o
    );

    modport master (
        output flush_i, valid_i, funct3_i, rs1_i, rs2_i, pc_i, imm_i,
               pred_taken_i, pred_target_i, ready_i,
        input  ready_o, valid_o, taken_o, redirect_pc_o, mispredict_o,
               illegal_o, misaligned_o, branch_cnt_o, mispred_cnt_o
    );

endinterface

// File: rtl/branch_resolve_unit_cmp.sv
// Combinational B-type condition evaluator: signed/unsigned compare plus illegal-encoding detect.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            taken_o,
    output logic            illegal_o
);

    logic isEqual;
    logic isLessSigned;
    logic isLessUnsigned;

    assign isEqual        = (rs1_i == rs2_i);
    assign isLessSigned   = ($signed(rs1_i) < $signed(rs2_i));
    assign isLessUnsigned = (rs1_i < rs2_i);

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = isEqual;
            F3_BNE:  taken_o = !isEqual;
            F3_BLT:  taken_o = isLessSigned;
            F3_BGE:  taken_o = !isLessSigned;
            F3_BLTU: taken_o = isLessUnsigned;
            F3_BGEU: taken_o = !isLessUnsigned;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolver top: target arithmetic, prediction check and a one-entry valid/ready output stage.
// Optional performance counters are enabled with the BRANCH_PERF_CNT_EN macro.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = XLEN_DEFAULT,
    parameter int INSTR_BYTES = INSTR_BYTES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    branch_resolve_unit_if.slave  bus
);

    logic            cmpTaken;
    logic            cmpIllegal;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fallThrough;
    logic            mispredictNow;
    logic            misalignedNow;
    logic            accept;
    logic            handshakeOut;

    logic            valid_q,      valid_d;
    logic            taken_q,      taken_d;
    logic [XLEN-1:0] redirectPc_q, redirectPc_d;
    logic            mispredict_q, mispredict_d;
    logic            illegal_q,    illegal_d;
    logic            misaligned_q, misaligned_d;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3_i  (bus.funct3_i),
        .rs1_i     (bus.rs1_i),
        .rs2_i     (bus.rs2_i),
        .taken_o   (cmpTaken),
        .illegal_o (cmpIllegal)
    );

    assign target        = bus.pc_i + bus.imm_i;
    assign fallThrough   = bus.pc_i + XLEN'(INSTR_BYTES);
    // Illegal encodings never claim a mispredict, whatever fetch guessed.
    assign mispredictNow = !cmpIllegal &
                           ((cmpTaken != bus.pred_taken_i) |
                            (cmpTaken & bus.pred_taken_i & (bus.pred_target_i != target)));
    assign misalignedNow = cmpTaken & target[1];

    assign bus.ready_o = !valid_q | bus.ready_i;
    assign accept      = bus.valid_i & bus.ready_o;
    assign handshakeOut = valid_q & bus.ready_i;

    always_comb begin
        valid_d      = valid_q;
        taken_d      = taken_q;
        redirectPc_d = redirectPc_q;
        mispredict_d = mispredict_q;
        illegal_d    = illegal_q;
        misaligned_d = misaligned_q;
        if (bus.flush_i) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d      = 1'b1;
            taken_d      = cmpTaken;
            redirectPc_d = cmpTaken ? target : fallThrough;
            mispredict_d = mispredictNow;
            illegal_d    = cmpIllegal;
            misaligned_d = misalignedNow;
        end else if (bus.ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            redirectPc_q <= '0;
            mispredict_q <= 1'b0;
            illegal_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            taken_q      <= taken_d;
            redirectPc_q <= redirectPc_d;
            mispredict_q <= mispredict_d;
            illegal_q    <= illegal_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.valid_o       = valid_q;
    assign bus.taken_o       = taken_q;
    assign bus.redirect_pc_o = redirectPc_q;
    assign bus.mispredict_o  = mispredict_q;
    assign bus.illegal_o     = illegal_q;
    assign bus.misaligned_o  = misaligned_q;

`ifdef BRANCH_PERF_CNT_EN
    logic [CNT_W-1:0] branchCnt_q;
    logic [CNT_W-1:0] mispredCnt_q;

    // Counting follows the output handshake, so a flush in the same cycle does not suppress it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branchCnt_q  <= '0;
            mispredCnt_q <= '0;
        end else if (handshakeOut) begin
            if (!illegal_q) begin
                branchCnt_q <= branchCnt_q + 1'b1;
            end
            if (mispredict_q) begin
                mispredCnt_q <= mispredCnt_q + 1'b1;
            end
        end
    end

    assign bus.branch_cnt_o  = branchCnt_q;
    assign bus.mispred_cnt_o = mispredCnt_q;
`else
    logic unusedHandshake;
    assign unusedHandshake   = handshakeOut;
    assign bus.branch_cnt_o  = {CNT_W{1'b0}};
    assign bus.mispred_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit; counter expectations follow BRANCH_PERF_CNT_EN.
module tb_branch_resolve_unit;
    import branch_pkg::*;

`ifdef BRANCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    branch_resolve_unit_if #(.XLEN(32), .CNT_W(32)) bus ();

    branch_resolve_unit #(.XLEN(32), .INSTR_BYTES(4), .CNT_W(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Observed result packed as {valid, taken, mispredict, illegal, misaligned, redirect_pc}.
    logic [36:0] obs;
    assign obs = {bus.valid_o, bus.taken_o, bus.mispredict_o, bus.illegal_o,
                  bus.misaligned_o, bus.redirect_pc_o};

    function automatic logic [36:0] res(input logic v, input logic t, input logic m,
                                        input logic il, input logic ma, input logic [31:0] pc);
        return {v, t, m, il, ma, pc};
    endfunction

    task automatic drive_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic [31:0] imm,
                            input logic pt, input logic [31:0] ptgt);
        bus.valid_i       = 1'b1;
        bus.funct3_i      = f3;
        bus.rs1_i         = a;
        bus.rs2_i         = b;
        bus.pc_i          = pc;
        bus.imm_i         = imm;
        bus.pred_taken_i  = pt;
        bus.pred_target_i = ptgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        drive_op(3'b000, 0, 0, 0, 0, 1'b0, 0);
        bus.valid_i = 1'b0;
        tick();
        total++;
        if (obs !== res(0, 0, 0, 0, 0, 32'h0)) begin
            bad++; $display("[TB] FAIL reset_outputs: got %h expected %h", obs, res(0, 0, 0, 0, 0, 32'h0));
        end
        total++;
        if ({bus.branch_cnt_o, bus.mispred_cnt_o} !== 64'h0) begin
            bad++; $display("[TB] FAIL reset_counters: got %h expected 0", {bus.branch_cnt_o, bus.mispred_cnt_o});
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (bus.ready_o !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_ready: got %b expected 1", bus.ready_o);
        end
    endtask

    task automatic test_compare();
        bus.ready_i = 1'b1;
        drive_op(F3_BLT, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
        tick();
        total++;
        if (obs !== res(1, 1, 1, 0, 0, 32'h120)) begin
            bad++; $display("[TB] FAIL blt_signed: got %h expected %h", obs, res(1, 1, 1, 0, 0, 32'h120));
        end
        drive_op(F3_BLTU, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0);
        tick();
        total++;
        if (obs !== res(1, 0, 0, 0, 0, 32'h104)) begin
            bad++; $display("[TB] FAIL bltu_unsigned: got %h expected %h", obs, res(1, 0, 0, 0, 0, 32'h104));
        end
        drive_op(F3_BNE, 32'h3, 32'h3, 32'h500, 32'h40, 1'b1, 32'h540);
        tick();
        total++;
        if (obs !== res(1, 0, 1, 0, 0, 32'h504)) begin
            bad++; $display("[TB] FAIL bne_equal: got %h expected %h", obs, res(1, 0, 1, 0, 0, 32'h504));
        end
        drive_op(F3_BGEU, 32'h8000_0000, 32'h1, 32'h600, 32'h100, 1'b1, 32'h700);
        tick();
        total++;
        if (obs !== res(1, 1, 0, 0, 0, 32'h700)) begin
            bad++; $display("[TB] FAIL bgeu_taken: got %h expected %h", obs, res(1, 1, 0, 0, 0, 32'h700));
        end
        drive_op(F3_BGE, 32'h8000_0000, 32'h1, 32'h600, 32'h100, 1'b0, 32'h0);
        tick();
        total++;
        if (obs !== res(1, 0, 0, 0, 0, 32'h604)) begin
            bad++; $display("[TB] FAIL bge_signed: got %h expected %h", obs, res(1, 0, 0, 0, 0, 32'h604));
        end
        drive_op(F3_BEQ, 32'h5, 32'h5, 32'h200, 32'hFFFF_FFF0, 1'b1, 32'h1F4);
        tick();
        total++;
        if (obs !== res(1, 1, 1, 0, 0, 32'h1F0)) begin
            bad++; $display("[TB] FAIL beq_target_miss: got %h expected %h", obs, res(1, 1, 1, 0, 0, 32'h1F0));
        end
        bus.valid_i = 1'b0;
        tick();
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++; $display("[TB] FAIL drain_valid: got %b expected 0", bus.valid_o);
        end
    endtask

    task automatic test_back_to_back();
        bus.ready_i = 1'b1;
        drive_op(F3_BNE, 32'h1, 32'h2, 32'h300, 32'h40, 1'b1, 32'h340);
        tick();
        drive_op(F3_BGEU, 32'h1, 32'h2, 32'h400, 32'h80, 1'b1, 32'h480);
        bus.ready_i = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({bus.ready_o, obs} !== {1'b0, res(1, 1, 0, 0, 0, 32'h340)}) begin
                bad++; $display("[TB] FAIL hold_cycle%0d: got %h expected %h", i, {bus.ready_o, obs},
                                {1'b0, res(1, 1, 0, 0, 0, 32'h340)});
            end
            tick();
        end
        bus.ready_i = 1'b1;
        #1;
        total++;
        if ({bus.ready_o, obs} !== {1'b1, res(1, 1, 0, 0, 0, 32'h340)}) begin
            bad++; $display("[TB] FAIL release_first: got %h expected %h", {bus.ready_o, obs},
                            {1'b1, res(1, 1, 0, 0, 0, 32'h340)});
        end
        tick();
        bus.valid_i = 1'b0;
        total++;
        if (obs !== res(1, 0, 1, 0, 0, 32'h404)) begin
            bad++; $display("[TB] FAIL release_second: got %h expected %h", obs, res(1, 0, 1, 0, 0, 32'h404));
        end
        tick();
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++; $display("[TB] FAIL release_drain: got %b expected 0", bus.valid_o);
        end
    endtask

    task automatic test_illegal();
        bus.ready_i = 1'b1;
        drive_op(3'b010, 32'h7, 32'h7, 32'h800, 32'h10, 1'b1, 32'h810);
        tick();
        total++;
        if (obs !== res(1, 0, 0, 1, 0, 32'h804)) begin
            bad++; $display("[TB] FAIL illegal_010: got %h expected %h", obs, res(1, 0, 0, 1, 0, 32'h804));
        end
        drive_op(3'b011, 32'h7, 32'h8, 32'h900, 32'h10, 1'b0, 32'h0);
        tick();
        bus.valid_i = 1'b0;
        total++;
        if (obs !== res(1, 0, 0, 1, 0, 32'h904)) begin
            bad++; $display("[TB] FAIL illegal_011: got %h expected %h", obs, res(1, 0, 0, 1, 0, 32'h904));
        end
        tick();
    endtask

    task automatic test_flush();
        bus.ready_i = 1'b1;
        drive_op(F3_BEQ, 32'h1, 32'h1, 32'hA00, 32'h20, 1'b1, 32'hA20);
        tick();
        drive_op(F3_BEQ, 32'h2, 32'h2, 32'hB00, 32'h20, 1'b1, 32'hB20);
        bus.flush_i = 1'b1;
        #1;
        total++;
        if (bus.ready_o !== 1'b1) begin
            bad++; $display("[TB] FAIL flush_ready: got %b expected 1", bus.ready_o);
        end
        tick();
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++; $display("[TB] FAIL flush_valid: got %b expected 0", bus.valid_o);
        end
        tick();
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++; $display("[TB] FAIL flush_no_emit: got %b expected 0", bus.valid_o);
        end
        bus.ready_i = 1'b0;
        drive_op(F3_BEQ, 32'h3, 32'h3, 32'hC00, 32'h20, 1'b1, 32'hC20);
        tick();
        bus.valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.valid_o !== 1'b0) begin
            bad++; $display("[TB] FAIL async_reset_valid: got %b expected 0", bus.valid_o);
        end
        tick();
        rst_n = 1'b1;
        bus.ready_i = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        bus.ready_i = 1'b1;
        drive_op(F3_BGE, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h8, 1'b1, 32'h4);
        tick();
        total++;
        if (obs !== res(1, 1, 0, 0, 0, 32'h4)) begin
            bad++; $display("[TB] FAIL target_wrap: got %h expected %h", obs, res(1, 1, 0, 0, 0, 32'h4));
        end
        drive_op(F3_BGE, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h2, 1'b1, 32'hFFFF_FFFE);
        tick();
        total++;
        if (obs !== res(1, 1, 0, 0, 1, 32'hFFFF_FFFE)) begin
            bad++; $display("[TB] FAIL misaligned: got %h expected %h", obs, res(1, 1, 0, 0, 1, 32'hFFFF_FFFE));
        end
        drive_op(F3_BNE, 32'h5, 32'h5, 32'hFFFF_FFFC, 32'h2, 1'b0, 32'h0);
        tick();
        bus.valid_i = 1'b0;
        total++;
        if (obs !== res(1, 0, 0, 0, 0, 32'h0)) begin
            bad++; $display("[TB] FAIL fallthrough_wrap: got %h expected %h", obs, res(1, 0, 0, 0, 0, 32'h0));
        end
        tick();
    endtask

    task automatic test_perf_counters();
        logic [31:0] pc;
        logic        miss;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pc   = 32'h1000 + 32'(i) * 32'h10;
            miss = (i == 1) || (i == 5) || (i == 9);
            if (i == 3 || i == 7) begin
                drive_op(3'b010, 32'h1, 32'h1, pc, 32'h10, 1'b1, pc + 32'h10);
            end else begin
                drive_op(F3_BEQ, 32'h1, 32'h1, pc, 32'h10, 1'b1, miss ? pc + 32'h14 : pc + 32'h10);
            end
            tick();
        end
        bus.valid_i = 1'b0;
        tick();
        total++;
        if (bus.branch_cnt_o !== (PERF ? 32'd10 : 32'd0)) begin
            bad++; $display("[TB] FAIL branch_cnt: got %0d expected %0d", bus.branch_cnt_o, PERF ? 10 : 0);
        end
        total++;
        if (bus.mispred_cnt_o !== (PERF ? 32'd3 : 32'd0)) begin
            bad++; $display("[TB] FAIL mispred_cnt: got %0d expected %0d", bus.mispred_cnt_o, PERF ? 3 : 0);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_compare();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_wrap();
        test_perf_counters();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised next-generation branch resolver for the rv32i core.
- Performs its own XLEN-wide signed and unsigned operand compare for all six B-type conditions, computes the branch target, and checks the result against the fetch-stage prediction.
- Registers the result into a one-entry output stage with a valid/ready handshake. Sits between decode/execute and the PC-redirect logic.

Parameters:
- XLEN, 32, operand/PC width.
- INSTR_BYTES, 4, not-taken PC increment.
- CNT_W, 32, width of performance counters (optional feature only).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  drop the in-flight result, no output this cycle
- valid_i  in  1  branch op presented
- ready_o  out  1  unit can accept an op
- funct3_i  in  3  B-type condition
- rs1_i  in  XLEN  operand A
- rs2_i  in  XLEN  operand B
- pc_i  in  XLEN  branch PC
- imm_i  in  XLEN  sign-extended B-immediate
- pred_taken_i  in  1  fetch prediction
- pred_target_i  in  XLEN  predicted target
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts the result
- taken_o  out  1  resolved direction
- redirect_pc_o  out  XLEN  correct next PC
- mispredict_o  out  1  prediction wrong, redirect required
- illegal_o  out  1  funct3 is 010 or 011
- misaligned_o  out  1  taken target has bit[1] set
- branch_cnt_o  out  CNT_W  resolved branches (optional feature)
- mispred_cnt_o  out  CNT_W  mispredicts (optional feature)

Behaviour:
- Reset: clock is clk_i; reset rst_ni is asynchronous, active-low. All outputs and registers clear to 0.
- Conditions:
  - 000 BEQ: A==B.
  - 001 BNE: A!=B.
  - 100 BLT: signed A<B.
  - 101 BGE: signed A>=B.
  - 110 BLTU: unsigned A<B.
  - 111 BGEU: unsigned A>=B.
  - 010/011: taken=0, illegal=1, mispredict=0.
- Arithmetic: target = pc_i+imm_i, fall-through = pc_i+INSTR_BYTES, both modulo 2^XLEN (wrap silently).
- redirect_pc = taken ? target : fall-through.
- mispredict = (taken != pred_taken_i) | (taken & pred_taken_i & (pred_target_i != target)).
- misaligned = taken & target[1]. When misaligned=1, mispredict is still reported as computed.
- Handshake:
  - ready_o = !valid_o | ready_i.
  - An op is accepted when valid_i & ready_o. Its result appears on the outputs on the next edge (latency 1).
  - Outputs hold stable while valid_o & !ready_i.
  - Back-to-back ops run at full throughput when ready_i=1.
- flush_i:
  - At the edge, clears valid_o and does not capture a same-cycle input (flush wins over accept).
  - ready_o is unaffected combinationally.
- Reset mid-operation: the pending result is discarded and valid_o drops immediately (asynchronous).

Optional Feature:
- Macro: BRANCH_PERF_CNT_EN.
- Defined:
  - branch_cnt_o increments on each output handshake (valid_o & ready_i) of a non-illegal result.
  - mispred_cnt_o increments on the same handshake when mispredict_o=1.
  - Both counters wrap at 2^CNT_W, are unaffected by flush_i, and reset to 0.
- Undefined: both ports exist and are tied to 0; no counter flops are synthesised.

Decomposition:
- Package branch_pkg holds:
  - funct3 localparams F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - Default XLEN/INSTR_BYTES constants.
- One combinational sub-module, branch_cmp:
  - Inputs: funct3, rs1, rs2 (XLEN-parametrised).
  - Outputs: taken, illegal.
- The top module owns target arithmetic, the prediction check, the output register and the counters.

Test Plan:
- BLT, rs1=0xFFFF_FFFF, rs2=0x1, pc=0x100, imm=0x20, pred_taken=0 -> next cycle valid_o=1, taken=1, redirect=0x120, mispredict=1. BLTU with the same operands -> taken=0, redirect=0x104, mispredict=0.
- BEQ, rs1=rs2=5, pc=0x200, imm=0xFFFF_FFF0, pred_taken=1, pred_target=0x1F4 -> taken=1, redirect=0x1F0, mispredict=1 (target mismatch).
- ready_i=0 for 3 cycles with valid_i=1 -> first result held stable, ready_o=0, second op not accepted until ready_i=1; then both results delivered in order.
- funct3=010 -> illegal_o=1, taken=0, mispredict=0; with BRANCH_PERF_CNT_EN the counters do not increment.
- Accept an op, then flush_i=1 with a new valid_i in the same cycle -> valid_o=0 next cycle, no result emitted. rst_ni low mid-hold -> valid_o=0 asynchronously.
- pc=0xFFFF_FFFC, BGE taken, imm=8 -> redirect=0x4 (wrap). imm=0x2 -> misaligned_o=1. With BRANCH_PERF_CNT_EN, 10 handshakes with 3 mispredicts -> branch_cnt=10, mispred_cnt=3.
